stack_control_unit: RTL and testbench

//  Microsequencer for the 16-bit stack processor. Fetches opcodes via PC and decodes them.

---
 rtl/stack_control_unit_pkg.sv | 56 +++++
 rtl/stack_control_unit.sv | 146 ++++++++++++++
 tb/tb_stack_control_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/stack_control_unit_pkg.sv
// Shared definitions for the stack-processor microsequencer: state codes,
// opcode values and the increment/address/data select encodings.
package stack_control_unit_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 8'h00,
        ST_DECODE = 8'h01,
        ST_DEC1   = 8'h02,
        ST_RD_R1  = 8'h03,
        ST_DEC2   = 8'h04,
        ST_RD_R2  = 8'h05,
        ST_PUSH   = 8'h06,
        ST_IMM    = 8'h07,
        ST_DROP   = 8'h08,
        ST_SETSP  = 8'h09,
        ST_JMP    = 8'h0A,
        ST_HALT   = 8'h0B
    } state_t;

    typedef enum logic [1:0] {
        INC_P1 = 2'b00,
        INC_P2 = 2'b01,
        INC_M2 = 2'b10,
        INC_M1 = 2'b11
    } incc_t;

    typedef enum logic [1:0] {
        AS_PC   = 2'b00,
        AS_SR   = 2'b01,
        AS_R1   = 2'b10,
        AS_ZERO = 2'b11
    } addr_sel_t;

    typedef enum logic [1:0] {
        DS_ALU = 2'b00,
        DS_R1  = 2'b01,
        DS_R2  = 2'b10,
        DS_PC  = 2'b11
    } data_sel_t;

    localparam logic [OP_W-1:0] OP_PUSHI = 6'h10;
    localparam logic [OP_W-1:0] OP_DROP  = 6'h11;
    localparam logic [OP_W-1:0] OP_SETSP = 6'h12;
    localparam logic [OP_W-1:0] OP_JMP   = 6'h20;
    localparam logic [OP_W-1:0] OP_NOP   = 6'h30;
    localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

    // Opcodes 6'h00-0F are two-operand ALU instructions.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op[5:4] == 2'b00);
    endfunction

endpackage

// File: rtl/stack_control_unit.sv
// Microsequencer for the 16-bit stack processor: opcode fetch/decode FSM,
// Mealy datapath strobes and the memory ready handshake.
module stack_control_unit
    import stack_control_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   opcode,
    input  logic              memory_ready,
    output logic              cmd_w,
    output logic              R1_w,
    output logic              R2_w,
    output logic              SR_w,
    output logic              PC_w,
    output logic              SR_inc,
    output logic              PC_inc,
    output logic [1:0]        SR_incc,
    output logic [1:0]        PC_incc,
    output logic [3:0]        ALU_func,
    output logic [1:0]        addr_sel,
    output logic [1:0]        data_sel,
    output logic              memory_w,
    output logic              error,
    output logic [ADDR_W-1:0] addr
);

    state_t          r_state;
    logic [OP_W-1:0] r_op;
    logic            r_error;
    logic            w_alu_op;

    assign w_alu_op = is_alu_op(r_op);

    // Sequencer: opcode is captured in DECODE so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_op    <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH:  if (memory_ready) r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_op <= opcode;
                    if (is_alu_op(opcode)) begin
                        r_state <= ST_DEC1;
                    end else begin
                        case (opcode)
                            OP_PUSHI: r_state <= ST_IMM;
                            OP_DROP:  r_state <= ST_DROP;
                            OP_SETSP: r_state <= ST_DEC1;
                            OP_JMP:   r_state <= ST_DEC1;
                            OP_NOP:   r_state <= ST_FETCH;
                            OP_HALT:  r_state <= ST_HALT;
                            default: begin
                                r_error <= 1'b1;
                                r_state <= ST_HALT;
                            end
                        endcase
                    end
                end
                ST_DEC1:   r_state <= ST_RD_R1;
                ST_RD_R1: begin
                    if (memory_ready) begin
                        case (r_op)
                            OP_SETSP: r_state <= ST_SETSP;
                            OP_JMP:   r_state <= ST_JMP;
                            default:  r_state <= ST_DEC2;
                        endcase
                    end
                end
                ST_DEC2:   r_state <= ST_RD_R2;
                ST_RD_R2:  if (memory_ready) r_state <= ST_PUSH;
                ST_IMM:    if (memory_ready) r_state <= ST_PUSH;
                ST_PUSH:   if (memory_ready) r_state <= ST_FETCH;
                ST_DROP:   r_state <= ST_FETCH;
                ST_SETSP:  r_state <= ST_FETCH;
                ST_JMP:    r_state <= ST_FETCH;
                ST_HALT:   r_state <= ST_HALT;
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    // Output decode: wait-state completion strobes follow memory_ready; reset forces all low.
    always_comb begin
        cmd_w    = 1'b0;
        R1_w     = 1'b0;
        R2_w     = 1'b0;
        SR_w     = 1'b0;
        PC_w     = 1'b0;
        SR_inc   = 1'b0;
        PC_inc   = 1'b0;
        SR_incc  = 2'b00;
        PC_incc  = 2'b00;
        ALU_func = 4'h0;
        addr_sel = 2'b00;
        data_sel = 2'b00;
        memory_w = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    addr_sel = AS_PC;
                    cmd_w    = memory_ready;
                    PC_inc   = memory_ready;
                    PC_incc  = INC_P1;
                end
                ST_DEC1, ST_DEC2, ST_DROP: begin
                    SR_inc  = 1'b1;
                    SR_incc = INC_M1;
                end
                ST_RD_R1: begin
                    addr_sel = AS_SR;
                    R1_w     = memory_ready;
                end
                ST_RD_R2: begin
                    addr_sel = AS_SR;
                    R2_w     = memory_ready;
                end
                ST_IMM: begin
                    addr_sel = AS_PC;
                    R1_w     = memory_ready;
                    PC_inc   = memory_ready;
                    PC_incc  = INC_P1;
                end
                ST_PUSH: begin
                    addr_sel = AS_SR;
                    memory_w = 1'b1;
                    data_sel = w_alu_op ? DS_ALU : DS_R1;
                    ALU_func = w_alu_op ? r_op[3:0] : 4'h0;
                    SR_inc   = memory_ready;
                    SR_incc  = INC_P1;
                end
                ST_SETSP: SR_w = 1'b1;
                ST_JMP:   PC_w = 1'b1;
                default: ;
            endcase
        end
    end

    assign error = r_error;
    assign addr  = ADDR_W'({2'b00, r_op, r_state});

endmodule

// File: tb/tb_stack_control_unit.sv
// Self-checking bench: instruction streams expanded into expected per-step
// output bundles, with directed cases followed by randomized opcodes and latencies.
module tb_stack_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic        memory_ready = 1'b0;
    logic        cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc;
    logic [1:0]  SR_incc, PC_incc, addr_sel, data_sel;
    logic [3:0]  ALU_func;
    logic        memory_w, error;
    logic [15:0] addr;

    stack_control_unit #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memory_ready(memory_ready),
        .cmd_w(cmd_w), .R1_w(R1_w), .R2_w(R2_w), .SR_w(SR_w), .PC_w(PC_w),
        .SR_inc(SR_inc), .PC_inc(PC_inc), .SR_incc(SR_incc), .PC_incc(PC_incc),
        .ALU_func(ALU_func), .addr_sel(addr_sel), .data_sel(data_sel),
        .memory_w(memory_w), .error(error), .addr(addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cmd_w, r1_w, r2_w, sr_w, pc_w, sr_inc, pc_inc;
        logic [1:0] sr_incc, pc_incc;
        logic [3:0] alu;
        logic [1:0] asel, dsel;
        logic       mem_w, err;
        logic [7:0] hi;
    } obs_t;

    typedef struct packed {
        logic       is_mem, is_dec, set_err;
        logic [5:0] op;
        obs_t       hold;
        obs_t       done;
    } step_t;

    step_t      q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         fixed_lat = 1;
    logic [5:0] m_latch = 6'h00;
    logic       m_err = 1'b0;
    logic [5:0] cur_op = 6'h00;

    function automatic logic illegal(input logic [5:0] op);
        return !(op < 6'h10 || op == 6'h10 || op == 6'h11 || op == 6'h12 ||
                 op == 6'h20 || op == 6'h30 || op == 6'h3F);
    endfunction

    task automatic check(input string tag, input obs_t e_in);
        obs_t e, o;
        e     = e_in;
        e.err = m_err;
        e.hi  = {2'b00, m_latch};
        o = {cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc, SR_incc, PC_incc,
             ALU_func, addr_sel, data_sel, memory_w, error, addr[15:8]};
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s op=%02h observed=%h expected=%h", tag, cur_op, o, e);
        end
    endtask

    task automatic push_int(input obs_t d);
        step_t s = '0;
        s.done = d;
        q.push_back(s);
    endtask

    task automatic push_mem(input obs_t h, input obs_t d);
        step_t s = '0;
        s.is_mem = 1'b1;
        s.hold   = h;
        s.done   = d;
        q.push_back(s);
    endtask

    // Pop: decrement SR by one, then read at SR into R1 or R2.
    task automatic add_pop(input bit second);
        obs_t h = '0, d = '0;
        d.sr_inc = 1'b1; d.sr_incc = 2'b11;
        push_int(d);
        h.asel = 2'b01;
        d = h;
        if (second) d.r2_w = 1'b1; else d.r1_w = 1'b1;
        push_mem(h, d);
    endtask

    // Push: write at SR, SR += 1 when the write completes.
    task automatic add_push(input logic [1:0] ds, input logic [3:0] alu);
        obs_t h = '0, d;
        h.asel = 2'b01; h.dsel = ds; h.mem_w = 1'b1; h.alu = alu;
        d = h;
        d.sr_inc = 1'b1; d.sr_incc = 2'b00;
        push_mem(h, d);
    endtask

    task automatic reset_check();
        m_latch = 6'h00;
        m_err   = 1'b0;
        check("reset", '0);
        n_tests++;
        assert (addr === {8'h00, 8'(stack_control_unit_pkg::ST_FETCH)}) else begin
            n_fail++;
            $error("FAIL reset_addr observed=%h expected=%h", addr,
                   {8'h00, 8'(stack_control_unit_pkg::ST_FETCH)});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; memory_ready = 1'b1; opcode = 6'($urandom);
        #1 reset_check();
        @(negedge clk);
        memory_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic run_queue();
        step_t s;
        int    lat;
        while (q.size() > 0) begin
            s   = q.pop_front();
            lat = s.is_mem ? ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4))) : 0;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                memory_ready = 1'b0; opcode = 6'($urandom);
                #1 check("wait", s.hold);
            end
            @(negedge clk);
            memory_ready = s.is_mem ? 1'b1 : 1'($urandom_range(0, 1));
            opcode       = s.is_dec ? s.op : 6'($urandom);
            #1 check(s.is_dec ? "decode" : "step", s.done);
            if (s.is_dec) begin
                m_latch = s.op;
                if (s.set_err) m_err = 1'b1;
            end
        end
    endtask

    // Expand one instruction into its expected step sequence and run it.
    task automatic execute(input logic [5:0] op);
        obs_t  h = '0, d;
        step_t s = '0;
        bit    halted;
        cur_op = op;
        d = h; d.cmd_w = 1'b1; d.pc_inc = 1'b1;
        push_mem(h, d);
        s.is_dec = 1'b1; s.op = op; s.set_err = illegal(op);
        q.push_back(s);
        halted = (op == 6'h3F) || illegal(op);
        if (op < 6'h10) begin
            add_pop(1'b0); add_pop(1'b1); add_push(2'b00, op[3:0]);
        end else if (op == 6'h10) begin
            h = '0; d = h; d.r1_w = 1'b1; d.pc_inc = 1'b1;
            push_mem(h, d);
            add_push(2'b01, 4'h0);
        end else if (op == 6'h11) begin
            d = '0; d.sr_inc = 1'b1; d.sr_incc = 2'b11;
            push_int(d);
        end else if (op == 6'h12) begin
            add_pop(1'b0);
            d = '0; d.sr_w = 1'b1; push_int(d);
        end else if (op == 6'h20) begin
            add_pop(1'b0);
            d = '0; d.pc_w = 1'b1; push_int(d);
        end
        if (halted) begin
            for (int k = 0; k < 4; k++) push_int('0);
        end
        run_queue();
        if (halted) do_reset();
    endtask

    function automatic logic [5:0] pick_op();
        int unsigned r = $urandom_range(0, 19);
        logic [5:0]  x;
        if (r < 8) return 6'($urandom_range(0, 15));
        if (r < 10) return 6'h10;
        if (r == 10) return 6'h11;
        if (r == 11) return 6'h12;
        if (r == 12) return 6'h20;
        if (r < 16) return 6'h30;
        if (r == 16) return 6'h3F;
        if (r == 17) begin
            x = 6'($urandom);
            while (!illegal(x)) x = 6'($urandom);
            return x;
        end
        return 6'($urandom_range(0, 15));
    endfunction

    initial begin
        do_reset();

        // Directed: single-cycle memory latency as the memory model responds.
        fixed_lat = 1;
        execute(6'h30); execute(6'h30); execute(6'h03);
        execute(6'h10); execute(6'h20); execute(6'h12);
        execute(6'h11); execute(6'h0F); execute(6'h00);
        execute(6'h25);
        execute(6'h3F);

        // Long fetch stall, then reset asserted in the middle of a wait.
        fixed_lat = 5;
        execute(6'h30);
        fixed_lat = 1;
        execute(6'h10);
        cur_op = 6'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            memory_ready = 1'b0; opcode = 6'($urandom);
            #1 check("stall_pre_rst", '0);
        end
        @(posedge clk);
        #2 rst_n = 1'b0; memory_ready = 1'b1;
        #1 reset_check();
        @(negedge clk);
        memory_ready = 1'b0;
        rst_n = 1'b1;

        // Randomized opcodes and memory latencies.
        fixed_lat = 0;
        for (int n = 0; n < 300; n++) execute(pick_op());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
